// File: rtl/vga_text_pkg.sv
// Shared types, timing defaults and helpers for the VGA text engine.
// Holds the cell attribute layout, pipeline control bundle and colour expansion.
package vga_text_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  localparam int CHAR_W_D = 8;
  localparam int CHAR_H_D = 16;
  localparam int COLOR_W_D = 8;
  localparam bit SYNC_POL_D = 1'b0;
  localparam int BLINK_FRAMES_D = 30;

  localparam int LATENCY = 3;
  localparam int CW_MAX = 16;

  // Bit layout matches wr_data[13:0].
  typedef struct packed {
    logic [2:0] bg;
    logic [2:0] fg;
    logic [7:0] code;
  } attr_t;

  typedef struct packed {
    logic vld;
    logic act;
    logic hs;
    logic vs;
    logic fs;
    logic cur;
  } ctl_t;

  function automatic logic [CW_MAX-1:0] expand(
    input logic b
  );
    return {CW_MAX{b}};
  endfunction

endpackage

// File: rtl/vga_text_controller_if.sv
// Host write port into the character/attribute buffer.
// wr_en strobe, wr_addr cell index, wr_data {rsvd, bg, fg, code}.
interface vga_text_controller_if #(
  parameter int ADDR_W = 12
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_text_controller_font_rom.sv
// Synchronous glyph ROM: one registered row of CHAR_W bits per lookup.
// Ports: clk, en_i (advance), code_i, line_i -> bits_o one cycle later.
module font_rom #(
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16
) (
  input  logic                      clk,
  input  logic                      en_i,
  input  logic [7:0]                code_i,
  input  logic [$clog2(CHAR_H)-1:0] line_i,
  output logic [CHAR_W-1:0]         bits_o
);

  function automatic logic [7:0] glyph(
    input logic [7:0]  code,
    input int unsigned line
  );
    logic [7:0] g;
    g = 8'h00;
    unique case (1'b1)
      code == 8'h41: begin
        unique case (line)
          0: g = 8'h18;
          1: g = 8'h3C;
          4: g = 8'h7E;
          2, 3, 5, 6, 7: g = 8'h66;
          default: g = 8'h00;
        endcase
      end
      code == 8'hDB: g = 8'hFF;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (en_i) bits_o <= CHAR_W'(glyph(code_i, 32'(line_i)));
  end

endmodule

// File: rtl/vga_text_controller.sv
// VGA text-mode engine: raster counters, char buffer, font lookup, cursor.
// clk/rst/pix_en, host write port, cursor inputs -> RGB, syncs, blank_n, frame_start.
module vga_text_controller
  import vga_text_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int CHAR_W = CHAR_W_D,
  parameter int CHAR_H = CHAR_H_D,
  parameter int COLOR_W = COLOR_W_D,
  parameter bit SYNC_POL = SYNC_POL_D,
  parameter int BLINK_FRAMES = BLINK_FRAMES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  vga_text_controller_if.slave wr,
  input  logic cursor_en,
  input  logic [$clog2(H_ACTIVE/CHAR_W)-1:0] cursor_col,
  input  logic [$clog2(V_ACTIVE/CHAR_H)-1:0] cursor_row,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic hsync,
  output logic vsync,
  output logic blank_n,
  output logic frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS = H_ACTIVE / CHAR_W;
  localparam int ROWS = V_ACTIVE / CHAR_H;
  localparam int CELLS = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(CHAR_W);
  localparam int YW = $clog2(CHAR_H);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_en) begin
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_q <= '0;
        if (v_q == VW'(V_TOTAL - 1)) v_q <= '0;
        else v_q <= v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  ctl_t ctl0_d;
  logic [ADDR_W-1:0] raddr_d;
  logic [XW-1:0] xb0_d;
  logic [YW-1:0] line0_d;

  always_comb begin
    ctl0_d = '0;
    ctl0_d.vld = 1'b1;
    ctl0_d.act = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    ctl0_d.hs = (32'(h_q) >= H_ACTIVE + H_FP)
             && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    ctl0_d.vs = (32'(v_q) >= V_ACTIVE + V_FP)
             && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    ctl0_d.fs = (h_q == '0) && (v_q == '0);
    ctl0_d.cur = cursor_en && ctl0_d.act
              && (32'(h_q) / CHAR_W == 32'(cursor_col))
              && (32'(v_q) / CHAR_H == 32'(cursor_row))
              && (32'(v_q) % CHAR_H >= CHAR_H - 2);
    xb0_d = XW'(32'(h_q) % CHAR_W);
    line0_d = YW'(32'(v_q) % CHAR_H);
    // Blanking reads park on cell 0 so the index never leaves the array.
    raddr_d = '0;
    if (ctl0_d.act) begin
      raddr_d = ADDR_W'((32'(v_q) / CHAR_H) * COLS
                        + 32'(h_q) / CHAR_W);
    end
  end

  // Buffer has no reset: contents survive a mid-frame reset.
  attr_t mem [CELLS];
  attr_t cell1_q;

  always_ff @(posedge clk) begin
    if (wr.wr_en && (32'(wr.wr_addr) < CELLS)) begin
      mem[wr.wr_addr] <= attr_t'(wr.wr_data[13:0]);
    end
    if (pix_en) cell1_q <= mem[raddr_d];
  end

  logic unused_rsvd;
  assign unused_rsvd = ^wr.wr_data[15:14];

  ctl_t ctl1_q, ctl2_q;
  logic [XW-1:0] xb1_q, xb2_q;
  logic [YW-1:0] line1_q;
  logic [2:0] fg2_q, bg2_q;
  logic [CHAR_W-1:0] bits2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl1_q <= '0;
      xb1_q <= '0;
      line1_q <= '0;
      ctl2_q <= '0;
      xb2_q <= '0;
      fg2_q <= '0;
      bg2_q <= '0;
    end else if (pix_en) begin
      ctl1_q <= ctl0_d;
      xb1_q <= xb0_d;
      line1_q <= line0_d;
      ctl2_q <= ctl1_q;
      xb2_q <= xb1_q;
      fg2_q <= cell1_q.fg;
      bg2_q <= cell1_q.bg;
    end
  end

  font_rom #(
    .CHAR_W(CHAR_W),
    .CHAR_H(CHAR_H)
  ) u_rom (
    .clk   (clk),
    .en_i  (pix_en),
    .code_i(cell1_q.code),
    .line_i(line1_q),
    .bits_o(bits2)
  );

  logic blink_q;
  logic [FW-1:0] fcnt_q;
  logic on_d;
  logic [2:0] rgb_d;

  always_comb begin
    on_d = 1'b0;
    rgb_d = '0;
    if (ctl2_q.vld && ctl2_q.act) begin
      on_d = bits2[XW'(CHAR_W - 1) - xb2_q]
          || (ctl2_q.cur && blink_q);
      rgb_d = on_d ? fg2_q : bg2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red <= '0;
      green <= '0;
      blue <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      blank_n <= 1'b0;
      frame_start <= 1'b0;
      blink_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        red <= COLOR_W'(expand(rgb_d[2]));
        green <= COLOR_W'(expand(rgb_d[1]));
        blue <= COLOR_W'(expand(rgb_d[0]));
        hsync <= (ctl2_q.vld && ctl2_q.hs) ? SYNC_POL : ~SYNC_POL;
        vsync <= (ctl2_q.vld && ctl2_q.vs) ? SYNC_POL : ~SYNC_POL;
        blank_n <= ctl2_q.vld && ctl2_q.act;
        frame_start <= ctl2_q.vld && ctl2_q.fs;
        if (ctl2_q.vld && ctl2_q.fs) begin
          if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_q <= '0;
            blink_q <= ~blink_q;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
      end
    end
  end

endmodule
